onewire_presence_scan: RTL
==========================

// Module: onewire_presence_scan
// PURPOSE
//  Multi-channel 1-wire reset/presence-detect master. On request it drives
//  a reset pulse on up to NUM_CH open-drain 1-wire buses in parallel, samples
//  each bus for a slave presence pulse, and reports per-channel present/short
//  bitmaps. It sits between the chip top (SB_IO per pin: OE=owr_out[i],
//  D_OUT=0) and the sensor controllers, and optionally rescans autonomously.
// PARAMETERS
//  NUM_CH      4      number of 1-wire channels (1..16)
//  T_PRE       48     release/precheck cycles before the reset pulse (>=1)
//  T_RST_LOW   23040  reset-low cycles (480 us @ 48 MHz) (>=1)
//  T_SAMPLE    3360   cycles from release to presence sample (70 us) (>=1)
//  T_RECOVER   19680  cycles after sample before done (410 us) (>=1)
//  AUTO_GAP    0      idle cycles between automatic rescans; 0 = disabled
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  start     in   1       scan request, sampled in IDLE only
//  chan_en   in   NUM_CH  channel enable mask, latched when a scan starts
//  owr_in    in   NUM_CH  raw bus levels from pads (asynchronous)
//  owr_out   out  NUM_CH  1 = pull bus low (pad OE), 0 = release
//  busy      out  1       scan in progress
//  done      out  1       one-cycle pulse: results updated
//  present   out  NUM_CH  presence pulse detected on channel
//  short     out  NUM_CH  bus found low while released (stuck/short)
// BEHAVIOUR
//  - Interface: one clock clk; rst synchronous, active-high.
//  - Reset: owr_out=0, busy=0, done=0, present=0, short=0, state IDLE,
//    counters and latched mask=0. rst asserted mid-scan releases all buses
//    at the next edge and discards the scan (no done).
//  - owr_in passes a 2-FF synchroniser per channel; "bus low" below means
//    the synchronised level (2-cycle latency from pad).
//  - FSM: IDLE -> PRE -> LOW -> SETTLE -> RECOVER -> DONE -> IDLE.
//  - IDLE: busy=0. start=1 (or auto timer expiry) at edge 0: latch chan_en,
//    busy=1, counter cleared, go to PRE. start is ignored while busy.
//  - PRE (T_PRE cycles, all released): at the last cycle short_q[i] =
//    en[i] & bus_low[i].
//  - LOW (T_RST_LOW cycles): owr_out[i] = en[i] & ~short_q[i]; others 0.
//    owr_out high from edge T_PRE to edge T_PRE+T_RST_LOW exactly.
//  - SETTLE (T_SAMPLE cycles, released): at the last cycle pres_q[i] =
//    en[i] & ~short_q[i] & bus_low[i].
//  - RECOVER (T_RECOVER cycles, released), then DONE for 1 cycle:
//    present<=pres_q, short<=short_q, done=1, busy=0. done is high in the
//    cycle after edge T_PRE+T_RST_LOW+T_SAMPLE+T_RECOVER.
//  - present/short hold their values until the next DONE; disabled channels
//    report 0 in both maps.
//  - Auto mode (AUTO_GAP>0): gap counter starts at DONE, counts in IDLE; at
//    AUTO_GAP cycles it launches a scan with the last latched mask. A start
//    in IDLE preempts the timer. Simultaneous start and expiry: one scan,
//    fresh chan_en.
//  - chan_en=0 at start: full timing still runs, owr_out stays 0, maps = 0.
//  - Single shared down-counter, width $clog2(max T + 1); no wrap: each
//    phase loads its count and transitions on reaching 1.
// TESTING (NUM_CH=4, T_PRE=4, T_RST_LOW=20, T_SAMPLE=6, T_RECOVER=10)
//  1 start, en=4'hF, ch0/ch2 pulled low during SETTLE only -> owr_out=4'hF
//    on edges 4..24, done at 40, present=4'h5, short=0.
//  2 ch3 held low from before start, en=4'hF -> owr_out=4'h7 in LOW,
//    short=4'h8, present[3]=0.
//  3 en=4'h6, all channels respond -> owr_out=4'h6, present=4'h6.
//  4 start re-pulsed while busy -> no restart, single done at cycle 40.
//  5 rst asserted on cycle 10 (LOW) -> owr_out=0 next edge, no done,
//    present/short=0; new start runs full scan.
//  6 AUTO_GAP=8 -> second scan begins 8 cycles after first done with the
//    same mask, no start pulse needed.

Source files
------------

// File: rtl/onewire_presence_scan.sv
// Multi-channel 1-wire reset/presence master: drives a reset pulse on every enabled
// bus in parallel, samples for presence pulses and reports present/short bitmaps.
module onewire_presence_scan #(
  parameter int NUM_CH    = 4,
  parameter int T_PRE     = 48,
  parameter int T_RST_LOW = 23040,
  parameter int T_SAMPLE  = 3360,
  parameter int T_RECOVER = 19680,
  parameter int AUTO_GAP  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic [NUM_CH-1:0] owr_in,
  output logic [NUM_CH-1:0] owr_out,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] present,
  output logic [NUM_CH-1:0] short
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX    = max2(max2(T_PRE, T_RST_LOW), max2(T_SAMPLE, T_RECOVER));
  localparam int CW       = $clog2(T_MAX + 1);
  localparam int GW       = (AUTO_GAP > 1) ? $clog2(AUTO_GAP) : 1;
  localparam int GAP_LAST = (AUTO_GAP > 0) ? AUTO_GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOW, S_SETTLE, S_RECOVER, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              auto_arm_q, auto_arm_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_CH-1:0] short_q, short_d;
  logic [NUM_CH-1:0] pres_q, pres_d;
  logic [NUM_CH-1:0] owr_out_q, owr_out_d;
  logic [NUM_CH-1:0] present_map_q, present_map_d;
  logic [NUM_CH-1:0] short_map_q, short_map_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] bus_low;
  logic              last;
  logic              auto_fire;

  assign bus_low   = ~sync2_q;
  assign last      = (cnt_q == CW'(1));
  assign auto_fire = (AUTO_GAP > 0) && auto_arm_q && (gap_q == GW'(GAP_LAST));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    auto_arm_d    = auto_arm_q;
    en_d          = en_q;
    sync1_d       = owr_in;
    sync2_d       = sync1_q;
    short_d       = short_q;
    pres_d        = pres_q;
    owr_out_d     = owr_out_q;
    present_map_d = present_map_q;
    short_map_d   = short_map_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start || auto_fire) begin
          // An explicit start wins over the timer and takes a fresh mask.
          if (start) en_d = chan_en;
          state_d    = S_PRE;
          cnt_d      = CW'(T_PRE);
          busy_d     = 1'b1;
          auto_arm_d = 1'b0;
          gap_d      = '0;
          short_d    = '0;
          pres_d     = '0;
        end else if (auto_arm_q) begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_PRE: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          short_d   = en_q & bus_low;
          owr_out_d = en_q & ~bus_low;
          state_d   = S_LOW;
          cnt_d     = CW'(T_RST_LOW);
        end
      end
      S_LOW: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          owr_out_d = '0;
          state_d   = S_SETTLE;
          cnt_d     = CW'(T_SAMPLE);
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          pres_d  = en_q & ~short_q & bus_low;
          state_d = S_RECOVER;
          cnt_d   = CW'(T_RECOVER);
        end
      end
      S_RECOVER: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d       = S_DONE;
          cnt_d         = '0;
          present_map_d = pres_q;
          short_map_d   = short_q;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          auto_arm_d    = (AUTO_GAP > 0);
          gap_d         = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        owr_out_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      auto_arm_q    <= 1'b0;
      en_q          <= '0;
      sync1_q       <= '1;
      sync2_q       <= '1;
      short_q       <= '0;
      pres_q        <= '0;
      owr_out_q     <= '0;
      present_map_q <= '0;
      short_map_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      auto_arm_q    <= auto_arm_d;
      en_q          <= en_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      short_q       <= short_d;
      pres_q        <= pres_d;
      owr_out_q     <= owr_out_d;
      present_map_q <= present_map_d;
      short_map_q   <= short_map_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign owr_out = owr_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign present = present_map_q;
  assign short   = short_map_q;

endmodule
